if_stage: RTL

- Instruction-fetch stage of the pipelined RV32I core. Sits directly upstream of the decode stage.
- Owns the PC register, drives the instruction-memory address, and registers fetched words into the IF/ID pipeline register.
- Accepts stall from the hazard unit and branch/jump redirects from EX.
- Halts fetch on EBREAK so the top-level bench can detect end of program.

---
 rtl/if_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem addressing, IF/ID register.
// Optional fetch/stall counters are built when IF_PERF_CNT_EN is defined.
module if_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
    parameter logic [31:0] EBREAK_INSTR = 32'h0010_0073
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] imem_rdata,
    output logic [31:0] imem_addr,
    output logic [31:0] PC_out,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misalign_err
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] ifid_pc_q;
    logic [31:0] ifid_pc_d;
    logic [31:0] ifid_instr_q;
    logic [31:0] ifid_instr_d;
    logic        ifid_valid_q;
    logic        ifid_valid_d;
    logic        err_q;
    logic        err_d;
    logic        is_ebreak;

    assign is_ebreak = (imem_rdata == EBREAK_INSTR);

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: redirect always resumes, an unstalled EBREAK fetch halts
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = RUN;
        end else if (state_q == RUN && !stall && is_ebreak) begin
            state_d = HALTED;
        end
    end

    // Next PC / IF/ID values in priority redirect > halted > stall > advance
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        err_d        = err_q;
        if (redirect_valid) begin
            pc_d         = {redirect_pc[31:2], 2'b00};
            ifid_pc_d    = 32'd0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                err_d = 1'b1;
            end
        end else if (state_q == HALTED) begin
            if (!stall) begin
                ifid_pc_d    = 32'd0;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
        end else if (!stall) begin
            ifid_pc_d    = pc_q;
            ifid_instr_d = imem_rdata;
            ifid_valid_d = 1'b1;
            if (!is_ebreak) begin
                pc_d = pc_q + 32'd4;
            end
        end
    end

    // PC, IF/ID and sticky misalignment flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'd0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            err_q        <= err_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic fetch_inc;
    logic stall_inc;

    assign fetch_inc = !redirect_valid && state_q == RUN && !stall;
    assign stall_inc = stall && !redirect_valid;

    // Free-running wrap-around performance counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_count <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (fetch_inc) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (stall_inc) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

    assign PC_out       = pc_q;
    assign imem_addr    = pc_q;
    assign if_id_pc     = ifid_pc_q;
    assign if_id_instr  = ifid_instr_q;
    assign if_id_valid  = ifid_valid_q;
    assign halted       = (state_q == HALTED);
    assign misalign_err = err_q;

endmodule
